// File: rtl/apu_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg
// Shared types and constants for the APU multi-voice register bank.
//   voice_reg_t     : per-voice register index (low 3 address bits)
//   voice_control_t : CONTROL register layout (32 bits)
//   voice_config_t  : one voice's full configuration (CONTROL + 7 words)
//   apply_strobe    : byte-enable merge helper
// Optional feature macro: APU_VOICE_IRQ_EN (CONTROL bit 8 irq_enable).
// -----------------------------------------------------------------------------
package apu_pkg;

  typedef enum logic [2:0] {
    REG_CONTROL       = 3'd0,
    REG_INCREMENT     = 3'd1,
    REG_ATTACK_STEP   = 3'd2,
    REG_DECAY_STEP    = 3'd3,
    REG_RELEASE_STEP  = 3'd4,
    REG_SUSTAIN_TIME  = 3'd5,
    REG_ATTACK_LEVEL  = 3'd6,
    REG_SUSTAIN_LEVEL = 3'd7
  } voice_reg_t;

  // CONTROL bit positions
  localparam int CTRL_WAVE_ENABLE_BIT    = 0;
  localparam int CTRL_WAVE_START_BIT     = 1;
  localparam int CTRL_ADSR_ENABLE_BIT    = 2;
  localparam int CTRL_ADSR_START_BIT     = 3;
  localparam int CTRL_ADSR_IDLE_BIT      = 4;
  localparam int CTRL_IDLE_EVENT_BIT     = 5;
  localparam int CTRL_COMMIT_PENDING_BIT = 6;
  localparam int CTRL_COMMIT_BIT         = 7;
  localparam int CTRL_IRQ_ENABLE_BIT     = 8;
  localparam int CTRL_GAIN_LSB           = 16;

  // Number of plain 32-bit words behind CONTROL (INCREMENT..SUSTAIN_LEVEL)
  localparam int NUM_WORDS = 7;

  typedef struct packed {
    logic [15:0] gain;
    logic [6:0]  reserved;
    logic        irq_enable;
    logic        commit;
    logic        commit_pending;
    logic        idle_event;
    logic        adsr_idle;
    logic        adsr_start;
    logic        adsr_enable;
    logic        wave_start;
    logic        wave_enable;
  } voice_control_t;

  typedef struct packed {
    voice_control_t control;
    logic [31:0]    increment;
    logic [31:0]    attack_step;
    logic [31:0]    decay_step;
    logic [31:0]    release_step;
    logic [31:0]    sustain_time;
    logic [31:0]    attack_level;
    logic [31:0]    sustain_level;
  } voice_config_t;

  // Replace only the strobed bytes of old_word with new_word.
  function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apu_voice_slot.sv
// -----------------------------------------------------------------------------
// apu_voice_slot
// One voice: shadow registers written by the CPU, active registers updated
// atomically on a sample tick while a commit is pending, one-cycle start
// pulses, and adsr_idle synchronisation / rising-edge event capture.
// Ports:
//   clk_i, rst_n_i    : clock, synchronous active-low reset
//   write_en          : write addressed to this voice
//   write_reg         : register index within the voice
//   write_strobe      : byte enables
//   write_data        : write data
//   sample_tick       : audio sample strobe
//   adsr_idle         : raw ADSR idle input
//   read_reg          : register index to read
//   read_word         : shadow value of read_reg with live status bits (comb)
//   wave_enable/adsr_enable/gain/active_words : active configuration
//   wave_start/adsr_start : one-cycle pulses after a committing tick
//   irq_request       : idle_event & irq_enable (APU_VOICE_IRQ_EN only)
// Optional feature macro: APU_VOICE_IRQ_EN.
// -----------------------------------------------------------------------------
module apu_voice_slot
  import apu_pkg::*;
#(
  parameter int GAIN_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        write_en,
  input  logic [2:0]                  write_reg,
  input  logic [3:0]                  write_strobe,
  input  logic [31:0]                 write_data,
  input  logic                        sample_tick,
  input  logic                        adsr_idle,
  input  logic [2:0]                  read_reg,
  output logic [31:0]                 read_word,
  output logic                        wave_enable,
  output logic                        wave_start,
  output logic                        adsr_enable,
  output logic                        adsr_start,
  output logic [GAIN_WIDTH-1:0]       gain,
`ifdef APU_VOICE_IRQ_EN
  output logic                        irq_request,
`endif
  output logic [NUM_WORDS-1:0][31:0]  active_words
);

  // Shadow state
  logic                       wave_enable_reg;
  logic                       wave_start_reg;
  logic                       adsr_enable_reg;
  logic                       adsr_start_reg;
  logic [GAIN_WIDTH-1:0]      gain_reg;
  logic [NUM_WORDS-1:0][31:0] word_reg;
`ifdef APU_VOICE_IRQ_EN
  logic                       irq_enable_reg;
`endif

  // Active state
  logic                       act_wave_enable_reg;
  logic                       act_adsr_enable_reg;
  logic [GAIN_WIDTH-1:0]      act_gain_reg;
  logic [NUM_WORDS-1:0][31:0] act_word_reg;
  logic                       wave_pulse_reg;
  logic                       adsr_pulse_reg;

  // Status
  logic pending_reg;
  logic idle_sync_reg;
  logic idle_event_reg;

  logic ctrl_write;
  logic byte0_write;
  logic commit_fire;
  logic idle_rise;

  assign ctrl_write  = write_en && (write_reg == REG_CONTROL);
  assign byte0_write = ctrl_write && write_strobe[0];
  // pending_reg is the pre-write value, so a commit written in the tick cycle
  // waits for the following tick.
  assign commit_fire = sample_tick && pending_reg;
  assign idle_rise   = adsr_idle && !idle_sync_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wave_enable_reg     <= 1'b0;
      wave_start_reg      <= 1'b0;
      adsr_enable_reg     <= 1'b0;
      adsr_start_reg      <= 1'b0;
      gain_reg            <= '0;
      word_reg            <= '0;
`ifdef APU_VOICE_IRQ_EN
      irq_enable_reg      <= 1'b0;
`endif
      act_wave_enable_reg <= 1'b0;
      act_adsr_enable_reg <= 1'b0;
      act_gain_reg        <= '0;
      act_word_reg        <= '0;
      wave_pulse_reg      <= 1'b0;
      adsr_pulse_reg      <= 1'b0;
      pending_reg         <= 1'b0;
      idle_sync_reg       <= 1'b0;
      idle_event_reg      <= 1'b0;
    end else begin
      idle_sync_reg  <= adsr_idle;
      // Set wins over a coincident write-1-to-clear.
      idle_event_reg <= idle_rise ||
                        (idle_event_reg && !(byte0_write && write_data[CTRL_IDLE_EVENT_BIT]));

      wave_pulse_reg <= commit_fire && wave_start_reg;
      adsr_pulse_reg <= commit_fire && adsr_start_reg;
      pending_reg    <= (pending_reg && !commit_fire) ||
                        (byte0_write && write_data[CTRL_COMMIT_BIT]);

      // Commit copies the pre-write shadow; the start bits are consumed.
      if (commit_fire) begin
        act_wave_enable_reg <= wave_enable_reg;
        act_adsr_enable_reg <= adsr_enable_reg;
        act_gain_reg        <= gain_reg;
        act_word_reg        <= word_reg;
        wave_start_reg      <= 1'b0;
        adsr_start_reg      <= 1'b0;
      end

      // A coincident CPU write lands in the shadow after the commit clear.
      if (byte0_write) begin
        wave_enable_reg <= write_data[CTRL_WAVE_ENABLE_BIT];
        wave_start_reg  <= write_data[CTRL_WAVE_START_BIT];
        adsr_enable_reg <= write_data[CTRL_ADSR_ENABLE_BIT];
        adsr_start_reg  <= write_data[CTRL_ADSR_START_BIT];
      end
`ifdef APU_VOICE_IRQ_EN
      if (ctrl_write && write_strobe[1]) begin
        irq_enable_reg <= write_data[CTRL_IRQ_ENABLE_BIT];
      end
`endif
      for (int b = 0; b < GAIN_WIDTH; b++) begin
        if (ctrl_write && write_strobe[2 + b/8]) begin
          gain_reg[b] <= write_data[CTRL_GAIN_LSB + b];
        end
      end
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (write_en && (write_reg == 3'(w + 1))) begin
          word_reg[w] <= apply_strobe(word_reg[w], write_data, write_strobe);
        end
      end
    end
  end

  voice_control_t ctrl_word;

  always_comb begin
    ctrl_word                = '0;
    ctrl_word.wave_enable    = wave_enable_reg;
    ctrl_word.wave_start     = wave_start_reg;
    ctrl_word.adsr_enable    = adsr_enable_reg;
    ctrl_word.adsr_start     = adsr_start_reg;
    ctrl_word.adsr_idle      = idle_sync_reg;
    ctrl_word.idle_event     = idle_event_reg;
    ctrl_word.commit_pending = pending_reg;
`ifdef APU_VOICE_IRQ_EN
    ctrl_word.irq_enable     = irq_enable_reg;
`endif
    ctrl_word.gain           = 16'(gain_reg);
    if (read_reg == REG_CONTROL) begin
      read_word = ctrl_word;
    end else begin
      read_word = word_reg[read_reg - 3'd1];
    end
  end

  assign wave_enable  = act_wave_enable_reg;
  assign adsr_enable  = act_adsr_enable_reg;
  assign wave_start   = wave_pulse_reg;
  assign adsr_start   = adsr_pulse_reg;
  assign gain         = act_gain_reg;
  assign active_words = act_word_reg;
`ifdef APU_VOICE_IRQ_EN
  assign irq_request  = idle_event_reg && irq_enable_reg;
`endif

endmodule

// File: rtl/apu_voice_register_bank.sv
// -----------------------------------------------------------------------------
// apu_voice_register_bank
// Double-buffered configuration registers for VOICES synth voices behind one
// bus slave port. Address = {voice, voice_reg_t}.
// Ports:
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   write_i/write_strobe_i/write_address_i/write_data_i : write port
//   read_i/read_address_i   : read request
//   read_data_o/read_valid_o: registered read response (data 0 when not valid)
//   sample_tick_i           : audio sample strobe, applies pending commits
//   adsr_idle_i             : per-voice ADSR idle
//   wave_enable_o, wave_start_o, adsr_enable_o, adsr_start_o, gain_o,
//   phase_increment_o, attack_step_o, decay_step_o, release_step_o,
//   sustain_duration_o, attack_level_o, sustain_level_o : active config
//   irq_o                   : registered OR of idle_event & irq_enable
//                             (APU_VOICE_IRQ_EN only)
// Optional feature macro: APU_VOICE_IRQ_EN.
// -----------------------------------------------------------------------------
module apu_voice_register_bank
  import apu_pkg::*;
#(
  parameter  int VOICES     = 4,
  parameter  int GAIN_WIDTH = 16,
  localparam int VIDX_W     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              write_i,
  input  logic [3:0]                        write_strobe_i,
  input  logic [VIDX_W+2:0]                 write_address_i,
  input  logic [31:0]                       write_data_i,
  input  logic                              read_i,
  input  logic [VIDX_W+2:0]                 read_address_i,
  output logic [31:0]                       read_data_o,
  output logic                              read_valid_o,
  input  logic                              sample_tick_i,
  input  logic [VOICES-1:0]                 adsr_idle_i,
  output logic [VOICES-1:0]                 wave_enable_o,
  output logic [VOICES-1:0]                 wave_start_o,
  output logic [VOICES-1:0]                 adsr_enable_o,
  output logic [VOICES-1:0]                 adsr_start_o,
  output logic [VOICES-1:0][GAIN_WIDTH-1:0] gain_o,
  output logic [VOICES-1:0][31:0]           phase_increment_o,
  output logic [VOICES-1:0][31:0]           attack_step_o,
  output logic [VOICES-1:0][31:0]           decay_step_o,
  output logic [VOICES-1:0][31:0]           release_step_o,
  output logic [VOICES-1:0][31:0]           sustain_duration_o,
  output logic [VOICES-1:0][31:0]           attack_level_o,
`ifdef APU_VOICE_IRQ_EN
  output logic                              irq_o,
`endif
  output logic [VOICES-1:0][31:0]           sustain_level_o
);

  localparam int SLOTS = 2 ** VIDX_W;

  logic [VIDX_W-1:0] write_voice;
  logic [2:0]        write_reg;
  logic [VIDX_W-1:0] read_voice;
  logic [2:0]        read_reg;

  assign write_voice = write_address_i[VIDX_W+2:3];
  assign write_reg   = write_address_i[2:0];
  assign read_voice  = read_address_i[VIDX_W+2:3];
  assign read_reg    = read_address_i[2:0];

  // Padded to a full power of two so a voice index beyond VOICES reads 0
  // without a range compare.
  logic [SLOTS-1:0][31:0]                 slot_words;
  logic [VOICES-1:0][NUM_WORDS-1:0][31:0] active_words;
`ifdef APU_VOICE_IRQ_EN
  logic [VOICES-1:0]                      irq_src;
`endif

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_voice
    if (gi < VOICES) begin : g_slot
      apu_voice_slot #(
        .GAIN_WIDTH (GAIN_WIDTH)
      ) u_slot (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .write_en     (write_i && (write_voice == VIDX_W'(gi))),
        .write_reg    (write_reg),
        .write_strobe (write_strobe_i),
        .write_data   (write_data_i),
        .sample_tick  (sample_tick_i),
        .adsr_idle    (adsr_idle_i[gi]),
        .read_reg     (read_reg),
        .read_word    (slot_words[gi]),
        .wave_enable  (wave_enable_o[gi]),
        .wave_start   (wave_start_o[gi]),
        .adsr_enable  (adsr_enable_o[gi]),
        .adsr_start   (adsr_start_o[gi]),
        .gain         (gain_o[gi]),
`ifdef APU_VOICE_IRQ_EN
        .irq_request  (irq_src[gi]),
`endif
        .active_words (active_words[gi])
      );

      assign phase_increment_o[gi]  = active_words[gi][0];
      assign attack_step_o[gi]      = active_words[gi][1];
      assign decay_step_o[gi]       = active_words[gi][2];
      assign release_step_o[gi]     = active_words[gi][3];
      assign sustain_duration_o[gi] = active_words[gi][4];
      assign attack_level_o[gi]     = active_words[gi][5];
      assign sustain_level_o[gi]    = active_words[gi][6];
    end else begin : g_empty
      assign slot_words[gi] = '0;
    end
  end

  logic [31:0] read_data_reg;
  logic        read_valid_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      read_data_reg  <= '0;
      read_valid_reg <= 1'b0;
    end else begin
      read_valid_reg <= read_i;
      read_data_reg  <= read_i ? slot_words[read_voice] : '0;
    end
  end

  assign read_data_o  = read_data_reg;
  assign read_valid_o = read_valid_reg;

`ifdef APU_VOICE_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |irq_src;
    end
  end

  assign irq_o = irq_reg;
`endif

endmodule

// File: tb/tb_apu_voice_register_bank.sv
// Bench for apu_voice_register_bank: read responses are checked against a
// scoreboard queue, active outputs are checked directly after each edge.
module tb_apu_voice_register_bank;

  localparam int VOICES     = 4;
  localparam int GAIN_WIDTH = 16;
  localparam int VIDX_W     = 2;
  localparam int ADDR_W     = VIDX_W + 3;

`ifdef APU_VOICE_IRQ_EN
  localparam logic [31:0] IRQ_BIT = 32'h0000_0100;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0000_0000;
`endif

  logic                              clk_i = 1'b0;
  logic                              rst_n_i;
  logic                              write_i;
  logic [3:0]                        write_strobe_i;
  logic [ADDR_W-1:0]                 write_address_i;
  logic [31:0]                       write_data_i;
  logic                              read_i;
  logic [ADDR_W-1:0]                 read_address_i;
  logic [31:0]                       read_data_o;
  logic                              read_valid_o;
  logic                              sample_tick_i;
  logic [VOICES-1:0]                 adsr_idle_i;
  logic [VOICES-1:0]                 wave_enable_o;
  logic [VOICES-1:0]                 wave_start_o;
  logic [VOICES-1:0]                 adsr_enable_o;
  logic [VOICES-1:0]                 adsr_start_o;
  logic [VOICES-1:0][GAIN_WIDTH-1:0] gain_o;
  logic [VOICES-1:0][31:0]           phase_increment_o;
  logic [VOICES-1:0][31:0]           attack_step_o;
  logic [VOICES-1:0][31:0]           decay_step_o;
  logic [VOICES-1:0][31:0]           release_step_o;
  logic [VOICES-1:0][31:0]           sustain_duration_o;
  logic [VOICES-1:0][31:0]           attack_level_o;
  logic [VOICES-1:0][31:0]           sustain_level_o;
`ifdef APU_VOICE_IRQ_EN
  logic                              irq_o;
`endif

  apu_voice_register_bank #(
    .VOICES     (VOICES),
    .GAIN_WIDTH (GAIN_WIDTH)
  ) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .write_i            (write_i),
    .write_strobe_i     (write_strobe_i),
    .write_address_i    (write_address_i),
    .write_data_i       (write_data_i),
    .read_i             (read_i),
    .read_address_i     (read_address_i),
    .read_data_o        (read_data_o),
    .read_valid_o       (read_valid_o),
    .sample_tick_i      (sample_tick_i),
    .adsr_idle_i        (adsr_idle_i),
    .wave_enable_o      (wave_enable_o),
    .wave_start_o       (wave_start_o),
    .adsr_enable_o      (adsr_enable_o),
    .adsr_start_o       (adsr_start_o),
    .gain_o             (gain_o),
    .phase_increment_o  (phase_increment_o),
    .attack_step_o      (attack_step_o),
    .decay_step_o       (decay_step_o),
    .release_step_o     (release_step_o),
    .sustain_duration_o (sustain_duration_o),
    .attack_level_o     (attack_level_o),
`ifdef APU_VOICE_IRQ_EN
    .irq_o              (irq_o),
`endif
    .sustain_level_o    (sustain_level_o)
  );

  always #5 clk_i = ~clk_i;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [31:0] sb_q[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input int v, input int r, input logic [3:0] strb,
                          input logic [31:0] data, input logic tk);
    write_i         = 1'b1;
    write_address_i = {VIDX_W'(v), 3'(r)};
    write_strobe_i  = strb;
    write_data_i    = data;
    sample_tick_i   = tk;
    step();
    write_i         = 1'b0;
    sample_tick_i   = 1'b0;
  endtask

  task automatic do_read(input int v, input int r, input logic [31:0] exp);
    read_i         = 1'b1;
    read_address_i = {VIDX_W'(v), 3'(r)};
    sb_q.push_back(exp);
    step();
    read_i         = 1'b0;
  endtask

  task automatic pulse_tick();
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
  endtask

  // Read response monitor: pops the scoreboard on every valid response.
  always @(negedge clk_i) begin
    if (read_valid_o) begin
      if (sb_q.size() == 0) begin
        check_value("rd_unexpected", 32'd1, 32'd0);
      end else begin
        logic [31:0] exp;
        exp = sb_q.pop_front();
        check_value("rd_data", read_data_o, exp);
        $display("read  addr=0x%02h data=0x%08h exp=0x%08h", read_address_i, read_data_o, exp);
      end
    end else begin
      check_value("rd_idle_zero", read_data_o, 32'd0);
    end
  end

  initial begin
    rst_n_i         = 1'b0;
    write_i         = 1'b0;
    write_strobe_i  = '0;
    write_address_i = '0;
    write_data_i    = '0;
    read_i          = 1'b0;
    read_address_i  = '0;
    sample_tick_i   = 1'b0;
    adsr_idle_i     = '0;
    repeat (3) step();

    // Reset state
    check_value("rst_valid", 32'(read_valid_o), 32'd0);
    check_value("rst_wave_en", 32'(wave_enable_o), 32'd0);
    check_value("rst_wave_st", 32'(wave_start_o), 32'd0);
    check_value("rst_adsr_en", 32'(adsr_enable_o), 32'd0);
    check_value("rst_adsr_st", 32'(adsr_start_o), 32'd0);
    check_value("rst_gain1", 32'(gain_o[1]), 32'd0);
    check_value("rst_incr2", phase_increment_o[2], 32'd0);
    check_value("rst_sus_lvl0", sustain_level_o[0], 32'd0);
    rst_n_i = 1'b1;
    step();

    for (int r = 0; r < 8; r++) do_read(0, r, 32'd0);
    step();

    // Byte strobes on voice 2 INCREMENT; active stays 0 without commit.
    do_write(2, 1, 4'hF, 32'h1234_5678, 1'b0);
    do_write(2, 1, 4'h2, 32'h0000_AB00, 1'b0);
    do_read(2, 1, 32'h1234_AB78);
    check_value("incr2_no_commit", phase_increment_o[2], 32'd0);
    pulse_tick();
    check_value("incr2_after_tick", phase_increment_o[2], 32'd0);

    // Voice 1 commit with start bits.
    do_write(1, 0, 4'hF, 32'hC000_008B, 1'b0);
    do_read(1, 0, 32'hC000_004B);
    check_value("v1_gain_pre", 32'(gain_o[1]), 32'd0);
    pulse_tick();
    check_value("v1_gain", 32'(gain_o[1]), 32'h0000_C000);
    check_value("v1_wave_en", 32'(wave_enable_o), 32'h2);
    check_value("v1_wave_st", 32'(wave_start_o), 32'h2);
    check_value("v1_adsr_st", 32'(adsr_start_o), 32'h2);
    check_value("v1_adsr_en", 32'(adsr_enable_o), 32'h0);
    step();
    check_value("v1_wave_st_end", 32'(wave_start_o), 32'h0);
    check_value("v1_adsr_st_end", 32'(adsr_start_o), 32'h0);
    do_read(1, 0, 32'hC000_0001);

    // Voice 0: commit write coincident with a tick waits for the next tick.
    do_write(0, 0, 4'hF, 32'h0001_0087, 1'b1);
    check_value("v0_same_tick_en", 32'(wave_enable_o), 32'h2);
    check_value("v0_same_tick_st", 32'(wave_start_o), 32'h0);
    check_value("v0_same_tick_gain", 32'(gain_o[0]), 32'h0);
    do_read(0, 0, 32'h0001_0047);
    pulse_tick();
    check_value("v0_wave_en", 32'(wave_enable_o), 32'h3);
    check_value("v0_wave_st", 32'(wave_start_o), 32'h1);
    check_value("v0_adsr_st", 32'(adsr_start_o), 32'h0);
    check_value("v0_adsr_en", 32'(adsr_enable_o), 32'h1);
    check_value("v0_gain", 32'(gain_o[0]), 32'h1);
    do_read(0, 0, 32'h0001_0005);

    // Voice 3 idle event, W1C, and set-wins-over-clear.
`ifdef APU_VOICE_IRQ_EN
    do_write(3, 0, 4'h2, 32'h0000_0100, 1'b0);
`endif
    adsr_idle_i = 4'b1000;
    step();
    step();
`ifdef APU_VOICE_IRQ_EN
    check_value("irq_set", 32'(irq_o), 32'd1);
`endif
    do_read(3, 0, 32'h0000_0030 | IRQ_BIT);
    do_write(3, 0, 4'h1, 32'h0000_0020, 1'b0);
    do_read(3, 0, 32'h0000_0010 | IRQ_BIT);
`ifdef APU_VOICE_IRQ_EN
    check_value("irq_clear", 32'(irq_o), 32'd0);
`endif
    adsr_idle_i = 4'b0000;
    step();
    adsr_idle_i = 4'b1000;
    do_write(3, 0, 4'h1, 32'h0000_0020, 1'b0);
    do_read(3, 0, 32'h0000_0030 | IRQ_BIT);
    do_write(3, 0, 4'h1, 32'h0000_0020, 1'b0);
    do_read(3, 0, 32'h0000_0010 | IRQ_BIT);

    // Reset between commit write and tick discards the commit.
    do_write(2, 0, 4'hF, 32'h0000_008B, 1'b0);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    pulse_tick();
    check_value("rst_mid_wave_st", 32'(wave_start_o), 32'h0);
    check_value("rst_mid_adsr_st", 32'(adsr_start_o), 32'h0);
    check_value("rst_mid_wave_en", 32'(wave_enable_o), 32'h0);
    check_value("rst_mid_gain1", 32'(gain_o[1]), 32'h0);
    do_read(2, 0, 32'h0000_0000);
    do_read(2, 1, 32'h0000_0000);
    step();
    step();

    check_value("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/apu_voice_register_bank.md
Name: apu_voice_register_bank

Overview:
Multi-voice successor to the single-voice waveform register block. It holds the oscillator, gain and ADSR configuration for VOICES independent synth voices behind one bus slave port. Configuration is double-buffered: the CPU writes shadow registers, and a per-voice commit copies them atomically into the active registers on the next audio sample tick, so voices never glitch mid-sample. It sits between the APU bus interface and the per-voice wave synth/ADSR datapaths.

Parameters:
VOICES, 4, number of voices; power of two, 1..16
GAIN_WIDTH, 16, width of the per-voice gain field, 1..16
VIDX_W, $clog2(VOICES) (min 1), derived, voice index width; not overridable

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous active-low reset
write_i  in  1  write request, single-cycle
write_strobe_i  in  4  byte enables
write_address_i  in  VIDX_W+3  {voice, voice_reg_t}
write_data_i  in  32  write data
read_i  in  1  read request
read_address_i  in  VIDX_W+3  {voice, voice_reg_t}
read_data_o  out  32  read data, registered
read_valid_o  out  1  read data valid, one cycle after read_i
sample_tick_i  in  1  one-cycle audio sample strobe
adsr_idle_i  in  VOICES  per-voice ADSR idle
wave_enable_o  out  VOICES  active wave enable
wave_start_o  out  VOICES  one-cycle start pulse
adsr_enable_o  out  VOICES  active ADSR enable
adsr_start_o  out  VOICES  one-cycle start pulse
gain_o  out  VOICES x GAIN_WIDTH  active gain
phase_increment_o  out  VOICES x 32  active increment
attack_step_o, decay_step_o, release_step_o, sustain_duration_o, attack_level_o, sustain_level_o  out  VOICES x 32 each  active ADSR values

Behaviour:
- Per-voice registers, index 0..7: CONTROL, INCREMENT, ATTACK_STEP, DECAY_STEP, RELEASE_STEP, SUSTAIN_TIME, ATTACK_LEVEL, SUSTAIN_LEVEL.
- CONTROL layout:
  - bit0 wave_enable, bit1 wave_start, bit2 adsr_enable, bit3 adsr_start.
  - bit4 adsr_idle: RO, live synchronised copy of the input.
  - bit5 idle_event: sticky, write-1-to-clear.
  - bit6 commit_pending: RO.
  - bit7 commit: WO, reads 0.
  - bits 15:8 reserved, read 0.
  - bits 31:16 gain; bits above GAIN_WIDTH read 0.
- Byte strobes: byte i is updated only if write_strobe_i[i]; unstrobed bytes keep their value. Writes go to the shadow registers only.
- Writing commit=1 with byte0 strobed sets commit_pending. On the next sample_tick_i while pending:
  - active <= shadow, all fields at once;
  - wave_start_o and adsr_start_o pulse for exactly one cycle, the cycle after the tick, if the shadow start bits were set;
  - shadow start bits and pending clear.
- Simultaneous events:
  - Write and tick in the same cycle: the tick commits the pre-write shadow; the write lands in the shadow.
  - Commit write coinciding with a tick: pending is set, and the commit applies on the following tick.
  - W1C of idle_event coinciding with a new idle rising edge: set wins.
- idle_event is set on a rising edge of adsr_idle_i per voice, registered one cycle.
- Reads:
  - 1-cycle latency; read_data_o returns the shadow value, with status bits live.
  - When read_valid_o is low, read_data_o is 0.
  - Reserved or unused addresses read 0 and ignore writes; a voice index >= VOICES is also ignored (only reachable when VOICES=1).
- Reset: all shadow/active registers, pending and idle_event are 0; all outputs are 0, including read_valid_o.
- Reset mid-commit: the pending commit is discarded.

Optional Feature:
Macro APU_VOICE_IRQ_EN.
- When defined: adds port irq_o (out, 1) and a per-voice CONTROL bit 8, irq_enable (shadow only, takes effect immediately). irq_o is the registered OR over voices of idle_event & irq_enable; it is 0 at reset.
- When undefined: no port, bit 8 reads 0, idle_event is polled.

Decomposition:
- Package apu_pkg holds:
  - voice_reg_t enum (8 entries, 3 bits);
  - voice_control_t packed struct (32 bits);
  - voice_config_t packed struct (control plus 7 words);
  - localparams for CONTROL bit positions.
- One sub-module, apu_voice_slot: one voice's shadow/active pair, commit logic, start pulses and idle edge detection. Generated VOICES times; the top level does address decode and read muxing.

Test Plan:
- Reset, then read every address of voice 0 -> read_valid_o 1 cycle later, data 0; all outputs 0.
- Voice 2: write INCREMENT=0x12345678 with strobe 0xF, then strobe 0x2 with data 0x0000AB00 -> read 0x1234AB78; phase_increment_o[2] stays 0 until a commit.
- Voice 1: CONTROL=0xC000_008B (gain 0xC000, commit, adsr_start, wave_start, wave_enable), then tick -> the next cycle shows gain_o[1]=0xC000, one-cycle start pulses, pending 0, and a CONTROL read of 0xC000_0001.
- Commit write and tick in the same cycle -> active unchanged; applies on the second tick; start pulses only then.
- Rising edge of adsr_idle_i[3] -> idle_event set; W1C clears it. With APU_VOICE_IRQ_EN and irq_enable=1, irq_o=1 until the clear.
- Assert rst_n_i low between the commit write and the tick -> no start pulse, pending 0, outputs 0.
